bit_packer: RTL and testbench

Variable-length field packer: accepts fields of 0–8 bits per handshake and concatenates them LSB-first into a 15-bit accumulator. It emits complete bytes on a valid/ready output stream. It is the writer end of the byte-window extraction path: the universal shifter pulls an 8-bit window out of a 15-bit span at a 3-bit offset, and this block builds that span from fields. A flush request drains residual bits as a zero-padded final byte.

---
 rtl/bit_packer.sv | 107 ++++++++++
 tb/tb_bit_packer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// =============================================================================
// Module   : bit_packer
// Brief    : Packs 0-8 bit fields LSB-first into a 15-bit span and emits bytes
//            on a valid/ready stream; flush drains residue as a padded byte.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module bit_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [3:0] in_len,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       flush_done
);

    localparam logic [3:0] c_BYTE = 4'd8;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic [14:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_flush_done;

    logic        w_out_fire;
    logic        w_in_fire;
    logic [3:0]  w_len;
    logic [7:0]  w_mask;
    logic [7:0]  w_field;
    logic [14:0] w_acc_shift;
    logic [3:0]  w_cnt_shift;
    logic [14:0] w_acc_next;
    logic [3:0]  w_cnt_next;

    assign out_data   = r_acc[7:0];
    assign out_valid  = (r_cnt >= c_BYTE) || ((r_state == FLUSH) && (r_cnt != 4'd0));
    assign out_last   = (r_state == FLUSH) && (r_cnt <= c_BYTE) && (r_cnt != 4'd0);
    assign flush_done = r_flush_done;

    // A full accumulator only takes a field when a byte leaves in the same cycle.
    assign in_ready   = (r_state == RUN) && !flush && ((r_cnt < c_BYTE) || out_ready);

    assign w_out_fire = out_valid && out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_len      = (in_len > c_BYTE) ? c_BYTE : in_len;

    always_comb begin
        w_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_mask[i] = (4'(i) < w_len);
        end
    end

    assign w_field = in_data & w_mask;

    // Outgoing byte is removed first so the new field lands just above the survivors.
    assign w_acc_shift = w_out_fire ? {8'h00, r_acc[14:8]} : r_acc;
    assign w_cnt_shift = w_out_fire ? ((r_cnt >= c_BYTE) ? (r_cnt - c_BYTE) : 4'd0) : r_cnt;
    assign w_acc_next  = w_in_fire ? (w_acc_shift | (15'(w_field) << w_cnt_shift)) : w_acc_shift;
    assign w_cnt_next  = w_in_fire ? (w_cnt_shift + w_len) : w_cnt_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_acc        <= 15'd0;
            r_cnt        <= 4'd0;
            r_flush_done <= 1'b0;
        end else begin
            r_acc        <= w_acc_next;
            r_cnt        <= w_cnt_next;
            r_flush_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (flush) begin
                        // Nothing left once any same-cycle byte leaves: complete at once.
                        if (w_cnt_shift == 4'd0) begin
                            r_flush_done <= 1'b1;
                        end else begin
                            r_state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if ((w_out_fire && out_last) || (r_cnt == 4'd0)) begin
                        r_state      <= RUN;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bit_packer.sv
// =============================================================================
// Module   : tb_bit_packer
// Brief    : Directed self-checking bench for bit_packer.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_bit_packer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       flush_done;

    int n_vec;
    int n_fail;

    bit_packer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_len     (in_len),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        #1;
        chk("send_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_len    = 4'd5;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset with inputs active
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_data", 16'(out_data), 16'h00);
        chk("rst_flush_done", 16'(flush_done), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        cyc();
        cyc();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_out_valid", 16'(out_valid), 16'd0);
        end

        // Eight single-bit fields
        send(8'h01, 4'd1); send(8'h00, 4'd1); send(8'h01, 4'd1); send(8'h01, 4'd1);
        send(8'h00, 4'd1); send(8'h00, 4'd1); send(8'h01, 4'd1); send(8'hFE, 4'd1);
        chk("bits_valid", 16'(out_valid), 16'd1);
        chk("bits_data", 16'(out_data), 16'h4D);
        chk("bits_last", 16'(out_last), 16'd0);
        cyc();
        chk("bits_drained", 16'(out_valid), 16'd0);

        // Masking of an over-wide field
        send(8'h1F, 4'd5);
        send(8'hFF, 4'd5);
        chk("mask_b0_valid", 16'(out_valid), 16'd1);
        chk("mask_b0_data", 16'(out_data), 16'hFF);
        send(8'h3F, 4'd6);
        chk("mask_b1_valid", 16'(out_valid), 16'd1);
        chk("mask_b1_data", 16'(out_data), 16'hFF);
        cyc();
        chk("mask_drained", 16'(out_valid), 16'd0);

        send(8'h1F, 4'd5);
        send(8'h00, 4'd5);
        chk("zero_b0_data", 16'(out_data), 16'h1F);
        send(8'h3F, 4'd6);
        chk("zero_b1_data", 16'(out_data), 16'hFC);
        cyc();
        chk("zero_drained", 16'(out_valid), 16'd0);

        // Backpressure with a full byte pending
        out_ready = 1'b0;
        send(8'hC3, 4'd8);
        in_valid = 1'b1;
        in_data  = 8'h96;
        in_len   = 4'd8;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            chk("bp_out_valid", 16'(out_valid), 16'd1);
            chk("bp_out_data", 16'(out_data), 16'hC3);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 16'(in_ready), 16'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_next_valid", 16'(out_valid), 16'd1);
        chk("bp_next_data", 16'(out_data), 16'h96);
        cyc();
        chk("bp_drained", 16'(out_valid), 16'd0);

        // Flush of three residual bits
        send(8'h05, 4'd3);
        flush = 1'b1;
        #1;
        chk("fl3_in_ready", 16'(in_ready), 16'd0);
        cyc();
        flush = 1'b0;
        chk("fl3_valid", 16'(out_valid), 16'd1);
        chk("fl3_last", 16'(out_last), 16'd1);
        chk("fl3_data", 16'(out_data), 16'h05);
        chk("fl3_done_early", 16'(flush_done), 16'd0);
        cyc();
        chk("fl3_done", 16'(flush_done), 16'd1);
        chk("fl3_empty", 16'(out_valid), 16'd0);
        cyc();
        chk("fl3_done_pulse", 16'(flush_done), 16'd0);

        // Flush with nothing buffered
        flush = 1'b1;
        #1;
        chk("fl0_valid_pre", 16'(out_valid), 16'd0);
        cyc();
        flush = 1'b0;
        chk("fl0_done", 16'(flush_done), 16'd1);
        chk("fl0_valid", 16'(out_valid), 16'd0);
        cyc();
        chk("fl0_done_pulse", 16'(flush_done), 16'd0);
        chk("fl0_valid_post", 16'(out_valid), 16'd0);

        // Flush with eleven bits: full byte then padded residue
        send(8'h06, 4'd3);
        send(8'hAB, 4'd8);
        out_ready = 1'b0;
        flush     = 1'b1;
        cyc();
        flush     = 1'b0;
        out_ready = 1'b1;
        chk("fl11_b0_valid", 16'(out_valid), 16'd1);
        chk("fl11_b0_last", 16'(out_last), 16'd0);
        chk("fl11_b0_data", 16'(out_data), 16'h5E);
        cyc();
        chk("fl11_b1_valid", 16'(out_valid), 16'd1);
        chk("fl11_b1_last", 16'(out_last), 16'd1);
        chk("fl11_b1_data", 16'(out_data), 16'h05);
        cyc();
        chk("fl11_done", 16'(flush_done), 16'd1);
        chk("fl11_empty", 16'(out_valid), 16'd0);
        cyc();

        // Sustained byte stream
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_len   = 4'd8;
            #1;
            chk("strm_ready", 16'(in_ready), 16'd1);
            if (i > 0) begin
                chk("strm_valid", 16'(out_valid), 16'd1);
                chk("strm_data", 16'(out_data), 16'(i - 1));
            end
            cyc();
        end
        in_valid = 1'b0;
        chk("strm_tail_data", 16'(out_data), 16'h3F);
        cyc();
        chk("strm_drained", 16'(out_valid), 16'd0);

        // Length above eight clamps to eight
        send(8'hA5, 4'd12);
        chk("len12_valid", 16'(out_valid), 16'd1);
        chk("len12_data", 16'(out_data), 16'hA5);
        cyc();
        chk("len12_drained", 16'(out_valid), 16'd0);

        // Reset in the middle of a stream
        send(8'h11, 4'd8);
        in_valid = 1'b1;
        in_data  = 8'h22;
        in_len   = 4'd8;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", 16'(out_valid), 16'd0);
        chk("mrst_data", 16'(out_data), 16'h00);
        chk("mrst_last", 16'(out_last), 16'd0);
        chk("mrst_in_ready", 16'(in_ready), 16'd1);
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mrst_idle_valid", 16'(out_valid), 16'd0);
            chk("mrst_idle_done", 16'(flush_done), 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
